// File: rtl/dsi_stream_crc.sv
// DSI payload checksum engine: CRC-16/MCRF4XX over a byte-lane stream, one beat per cycle.
// Optional length check against the DSI word count is enabled by DSI_CRC_LEN_CHECK_EN.
module dsi_stream_crc #(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [15:0]               cmd_wc,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [8*DATA_BYTES-1:0]   s_data,
  input  logic                      s_last,
  input  logic [((DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1)-1:0] s_nbytes,
  output logic                      crc_valid,
  input  logic                      crc_ready,
  output logic [15:0]               crc_out,
  output logic                      len_err
);

  localparam int unsigned NB = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e      state_q;
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  // Reflected polynomial 0x8408 == x^16+x^12+x^5+1 processed LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {8'h00, b};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

`ifdef DSI_CRC_LEN_CHECK_EN
  logic [16:0] cnt_q;
  logic [15:0] wc_q;
  logic [4:0]  nfold;
  logic [17:0] cnt_sum;
  logic [16:0] cnt_next;
  logic        len_err_q;
`else
  logic unused_wc;
  assign unused_wc = ^cmd_wc;
`endif

  always_comb begin
    crc_next = crc_q;
`ifdef DSI_CRC_LEN_CHECK_EN
    nfold = 5'd0;
`endif
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      // Bytes above s_nbytes on the last beat are padding.
      if (!s_last || (NB'(i) <= s_nbytes)) begin
        crc_next = crc_byte(crc_next, s_data[8*i +: 8]);
`ifdef DSI_CRC_LEN_CHECK_EN
        nfold = nfold + 5'd1;
`endif
      end
    end
  end

`ifdef DSI_CRC_LEN_CHECK_EN
  always_comb begin
    cnt_sum  = {1'b0, cnt_q} + 18'(nfold);
    cnt_next = cnt_sum[17] ? 17'h1FFFF : cnt_sum[16:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      crc_q     <= CRC_INIT;
      cmd_ready <= 1'b1;
      s_ready   <= 1'b0;
      crc_valid <= 1'b0;
`ifdef DSI_CRC_LEN_CHECK_EN
      cnt_q     <= 17'd0;
      wc_q      <= 16'd0;
      len_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            crc_q     <= CRC_INIT;
            cmd_ready <= 1'b0;
`ifdef DSI_CRC_LEN_CHECK_EN
            cnt_q     <= 17'd0;
            wc_q      <= cmd_wc;
            len_err_q <= 1'b0;
`endif
            if (cmd_wc == 16'd0) begin
              state_q   <= StDone;
              crc_valid <= 1'b1;
            end else begin
              state_q <= StAccum;
              s_ready <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (s_valid) begin
            crc_q <= crc_next;
`ifdef DSI_CRC_LEN_CHECK_EN
            cnt_q <= cnt_next;
`endif
            if (s_last) begin
              state_q   <= StDone;
              s_ready   <= 1'b0;
              crc_valid <= 1'b1;
`ifdef DSI_CRC_LEN_CHECK_EN
              len_err_q <= (cnt_next != {1'b0, wc_q});
`endif
            end
          end
        end
        StDone: begin
          if (crc_ready) begin
            state_q   <= StIdle;
            crc_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
          s_ready   <= 1'b0;
          crc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign crc_out = crc_q;

`ifdef DSI_CRC_LEN_CHECK_EN
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_dsi_stream_crc.sv
// Directed bench for dsi_stream_crc: 4-byte lanes for the main sequence, 1-byte lanes for
// the byte-serial reference vector "123456789" -> 16'h6F91.
module tb_dsi_stream_crc;

  logic        clk;
  logic        reset;
  // 4-byte instance
  logic        cmd_valid, cmd_ready, s_valid, s_ready, s_last, crc_valid, crc_ready, len_err;
  logic [15:0] cmd_wc, crc_out;
  logic [31:0] s_data;
  logic [1:0]  s_nbytes;
  // 1-byte instance
  logic        cmd_valid1, cmd_ready1, s_valid1, s_ready1, s_last1, crc_valid1, crc_ready1;
  logic        len_err1;
  logic [15:0] cmd_wc1, crc_out1;
  logic [7:0]  s_data1;
  logic        s_nbytes1;

  int n_cmp;
  int n_fail;

`ifdef DSI_CRC_LEN_CHECK_EN
  localparam logic LEN_ERR_SHORT = 1'b1;
`else
  localparam logic LEN_ERR_SHORT = 1'b0;
`endif

  dsi_stream_crc #(.DATA_BYTES(4), .CRC_INIT(16'hFFFF)) u_dut4 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wc(cmd_wc),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .s_nbytes(s_nbytes),
    .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out), .len_err(len_err)
  );

  dsi_stream_crc #(.DATA_BYTES(1), .CRC_INIT(16'hFFFF)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_wc(cmd_wc1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1), .s_last(s_last1),
    .s_nbytes(s_nbytes1),
    .crc_valid(crc_valid1), .crc_ready(crc_ready1), .crc_out(crc_out1), .len_err(len_err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one beat, optionally after an idle gap, and returns just after it is accepted.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] nb,
                           input int gap);
    int n;
    repeat (gap) step();
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    s_nbytes = nb;
    n = 0;
    while (!s_ready && n < 20) begin
      step();
      n++;
    end
    check("s_ready_wait", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'hDEAD_BEEF;
  endtask

  // Command plus "123456789" as three beats; garbage in bytes 1-3 of the last beat.
  task automatic send_pkt(input logic [15:0] wc, input bit gaps);
    cmd_valid = 1'b1;
    cmd_wc    = wc;
    step();
    cmd_valid = 1'b0;
    check("cmd_accept_sready", s_ready, 1'b1);
    send_beat(32'h3433_3231, 1'b0, 2'd3, gaps ? int'($urandom_range(0, 3)) : 0);
    send_beat(32'h3837_3635, 1'b0, 2'd1, gaps ? int'($urandom_range(0, 3)) : 0);
    check("no_early_valid", crc_valid, 1'b0);
    send_beat(32'hAABB_CC39, 1'b1, 2'd0, gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1;
    cmd_valid = 0; cmd_wc = 0; s_valid = 0; s_data = 0; s_last = 0; s_nbytes = 0;
    crc_ready = 0;
    cmd_valid1 = 0; cmd_wc1 = 0; s_valid1 = 0; s_data1 = 0; s_last1 = 0; s_nbytes1 = 0;
    crc_ready1 = 0;

    step();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_crc_valid", crc_valid, 1'b0);
    check("rst_crc_out", crc_out, 16'hFFFF);
    check("rst_len_err", len_err, 1'b0);
    step();
    reset = 1'b0;

    // Byte-serial reference vector on the 1-byte instance.
    cmd_valid1 = 1'b1;
    cmd_wc1    = 16'd9;
    step();
    cmd_valid1 = 1'b0;
    check("b1_s_ready", s_ready1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      s_valid1 = 1'b1;
      s_data1  = 8'h31 + 8'(i);
      s_last1  = (i == 8);
      if (i == 8) check("b1_no_early_valid", crc_valid1, 1'b0);
      step();
    end
    s_valid1 = 1'b0;
    s_last1  = 1'b0;
    check("b1_crc_valid", crc_valid1, 1'b1);
    check("b1_crc_out", crc_out1, 16'h6F91);
    check("b1_len_err", len_err1, 1'b0);
    crc_ready1 = 1'b1;
    step();
    crc_ready1 = 1'b0;
    check("b1_release", crc_valid1, 1'b0);

    // s_valid in IDLE must not be consumed.
    s_valid = 1'b1;
    s_data  = 32'h1234_5678;
    step();
    check("idle_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;

    // 4-byte lanes, matching word count.
    send_pkt(16'd9, 1'b0);
    check("p1_crc_valid", crc_valid, 1'b1);
    check("p1_crc_out", crc_out, 16'h6F91);
    check("p1_len_err", len_err, 1'b0);

    // Backpressure with a pending command.
    cmd_valid = 1'b1;
    cmd_wc    = 16'd0;
    s_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_crc_out", crc_out, 16'h6F91);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_s_ready", s_ready, 1'b0);
      check("hold_crc_valid", crc_valid, 1'b1);
    end
    s_valid = 1'b0;

    // Release with cmd_valid high: command waits one cycle, then zero-length packet.
    crc_ready = 1'b1;
    step();
    crc_ready = 1'b0;
    check("rel_crc_valid", crc_valid, 1'b0);
    check("rel_cmd_ready", cmd_ready, 1'b1);
    check("idle_crc_hold", crc_out, 16'h6F91);
    step();
    cmd_valid = 1'b0;
    check("wc0_crc_valid", crc_valid, 1'b1);
    check("wc0_crc_out", crc_out, 16'hFFFF);
    check("wc0_s_ready", s_ready, 1'b0);
    check("wc0_len_err", len_err, 1'b0);
    crc_ready = 1'b1;
    step();
    crc_ready = 1'b0;
    check("wc0_release", cmd_ready, 1'b1);

    // Short packet against the word count, with random valid gaps.
    send_pkt(16'd10, 1'b1);
    check("p2_crc_valid", crc_valid, 1'b1);
    check("p2_crc_out", crc_out, 16'h6F91);
    check("p2_len_err", len_err, LEN_ERR_SHORT);
    crc_ready = 1'b1;
    step();
    crc_ready = 1'b0;

    // Reset mid-ACCUM abandons the packet.
    cmd_valid = 1'b1;
    cmd_wc    = 16'd9;
    step();
    cmd_valid = 1'b0;
    send_beat(32'h0102_0304, 1'b0, 2'd3, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_crc_valid", crc_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_crc_out", crc_out, 16'hFFFF);
    step();
    check("post_rst_crc_valid", crc_valid, 1'b0);
    send_pkt(16'd9, 1'b1);
    check("p3_crc_valid", crc_valid, 1'b1);
    check("p3_crc_out", crc_out, 16'h6F91);
    check("p3_len_err", len_err, 1'b0);
    crc_ready = 1'b1;
    step();
    crc_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
